led_pixel_shifter: RTL and testbench
====================================

LED_PIXEL_SHIFTER -- requirements
Module: led_pixel_shifter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of fetched pixel words.
REQ-002 SHALL have parameter NUM_LEDS, default 16, pixels (words) per frame; legal range 1..65535.
REQ-003 SHALL have parameters BIT_CYCLES=125, T0H=40, T1H=80, LATCH_CYCLES=5000: clk counts for bit period, 0-high time, 1-high time and latch low time; T0H<T1H<BIT_CYCLES.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port frame_start, input, 1: one-cycle pulse starting a frame.
REQ-007 SHALL have port frame_buf_id, input, DATA_WIDTH: buffer to display, sampled on accepted frame_start.
REQ-008 SHALL have port buf_id, output, DATA_WIDTH: latched buffer id, driven to the word-fetch stage.
REQ-009 SHALL have ports wb_request_first_word and wb_request_next_word, outputs, 1 each: one-cycle registered fetch requests.
REQ-010 SHALL have ports wb_recieved_new_word (input, 1, word-valid pulse) and wb_received_word (input, DATA_WIDTH, pixel word; GRB in bits [23:0]).
REQ-011 SHALL have ports led_dout (output, 1, serial LED line), busy (output, 1), frame_done (output, 1, one-cycle pulse), underrun (output, 1, sticky).

Function
REQ-012 SHALL implement states IDLE, FETCH, SHIFT, STALL, LATCH.
REQ-013 IDLE: frame_start accepted -> latch frame_buf_id into buf_id, clear counters and underrun, assert wb_request_first_word next cycle, go FETCH; frame_start outside IDLE SHALL be ignored.
REQ-014 At most one request SHALL be outstanding; a request sets the outstanding flag, an arrival with the flag set clears it; arrivals without the flag SHALL be ignored.
REQ-015 Arrival when shifter empty (FETCH/STALL) SHALL load bits [23:0] into the shift register and enter SHIFT; led_dout rises the cycle after the arrival.
REQ-016 Arrival during SHIFT SHALL load the one-word hold register (hold_valid=1).
REQ-017 wb_request_next_word SHALL pulse when state is SHIFT or STALL, no request outstanding, hold_valid=0, words requested < NUM_LEDS.
REQ-018 Each bit, MSB (bit 23) first: led_dout high for T1H (bit=1) or T0H (bit=0) cycles, then low until BIT_CYCLES cycles elapse; bits back-to-back with no gap.
REQ-019 After bit 0: pixels sent == NUM_LEDS -> LATCH; else hold_valid -> load shifter from hold in the same cycle, clear hold_valid, continue SHIFT without gap; else -> STALL.
REQ-020 STALL SHALL hold led_dout low, set underrun, and leave on next arrival per REQ-015.
REQ-021 LATCH SHALL hold led_dout low for LATCH_CYCLES cycles, then pulse frame_done one cycle and enter IDLE.
REQ-022 Words requested and pixels sent SHALL be 16-bit counters that never exceed NUM_LEDS; bits [DATA_WIDTH-1:24] of every word ignored.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 Arrival and hold-to-shifter transfer in the same cycle: transfer SHALL take old hold content and arrival SHALL refill hold; no word lost.

Reset
REQ-025 reset low at a clock edge SHALL force IDLE, led_dout=0, both requests=0, busy=0, frame_done=0, underrun=0, buf_id=0, hold_valid=0, outstanding cleared, counters 0.
REQ-026 Reset mid-frame SHALL abort immediately; a later word arrival SHALL be ignored.

Verification (BIT_CYCLES=8, T0H=2, T1H=5, LATCH_CYCLES=20, NUM_LEDS=3)
REQ-027 frame_start, frame_buf_id=7 -> buf_id=7, wb_request_first_word next cycle, busy=1, exactly 3 words requested.
REQ-028 Word 0x00800001 -> 24 bits of 8 cycles: first high 5, next 23 bits high 2 except last high 5.
REQ-029 Fetch stage answering within 4 cycles -> 3 pixels contiguous (576 cycles), 20 low cycles, one frame_done, underrun=0.
REQ-030 Second word delayed 300 cycles -> led_dout low in STALL, underrun=1, third pixel intact, frame completes.
REQ-031 Unsolicited arrival in IDLE and frame_start during SHIFT -> no state change, no extra request.
REQ-032 reset low during pixel 2 -> all outputs at reset values next cycle; new frame_start runs a clean frame.

Source files
------------

// File: rtl/led_pixel_shifter_if.sv
// Bundle of the frame-control, word-fetch and LED-line signals of the pixel shifter.
// The master modport is the shifter itself; the slave modport is the frame
// controller / word-fetch side that talks to it.
interface led_pixel_shifter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  frame_start;
    logic [DATA_WIDTH-1:0] frame_buf_id;
    logic [DATA_WIDTH-1:0] buf_id;
    logic                  wb_request_first_word;
    logic                  wb_request_next_word;
    logic                  wb_recieved_new_word;
    logic [DATA_WIDTH-1:0] wb_received_word;
    logic                  led_dout;
    logic                  busy;
    logic                  frame_done;
    logic                  underrun;

    modport master (
        input  frame_start, frame_buf_id, wb_recieved_new_word, wb_received_word,
        output buf_id, wb_request_first_word, wb_request_next_word,
               led_dout, busy, frame_done, underrun
    );

    modport slave (
        output frame_start, frame_buf_id, wb_recieved_new_word, wb_received_word,
        input  buf_id, wb_request_first_word, wb_request_next_word,
               led_dout, busy, frame_done, underrun
    );
endinterface

// File: rtl/led_pixel_shifter.sv
// Serialises a frame of GRB pixel words onto a single-wire LED chain.
// Words are fetched one at a time (at most one request outstanding) into a
// one-word hold register so consecutive pixels go out without a gap; if the
// fetch stage is too slow the line idles low and the sticky underrun flag is set.
module led_pixel_shifter #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_LEDS     = 16,
    parameter int BIT_CYCLES   = 125,
    parameter int T0H          = 40,
    parameter int T1H          = 80,
    parameter int LATCH_CYCLES = 5000
) (
    input  logic clk,
    input  logic reset,
    led_pixel_shifter_if.master bus
);
    localparam logic [15:0] NUM_LEDS_W = 16'(NUM_LEDS);
    localparam logic [15:0] BIT_LAST   = 16'(BIT_CYCLES - 1);
    localparam logic [15:0] T0H_W      = 16'(T0H);
    localparam logic [15:0] T1H_W      = 16'(T1H);
    localparam logic [31:0] LATCH_LAST = 32'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHIFT = 3'd2,
        STALL = 3'd3,
        LATCH = 3'd4
    } state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] buf_id_reg, buf_id_next;
    logic [23:0]           shift_reg, shift_next;
    logic [23:0]           hold_reg, hold_next;
    logic                  hold_valid_reg, hold_valid_next;
    logic                  outstanding_reg, outstanding_next;
    logic [4:0]            bit_idx_reg, bit_idx_next;
    logic [15:0]           bit_cnt_reg, bit_cnt_next;
    logic [31:0]           latch_cnt_reg, latch_cnt_next;
    logic [15:0]           words_req_reg, words_req_next;
    logic [15:0]           pixels_sent_reg, pixels_sent_next;
    logic                  req_first_reg, req_first_next;
    logic                  req_next_reg, req_next_next;
    logic                  led_reg, led_next;
    logic                  busy_reg, busy_next;
    logic                  frame_done_reg, frame_done_next;
    logic                  underrun_reg, underrun_next;

    logic                  arrival;
    logic                  bit_end;
    logic                  pixel_end;
    logic                  last_pixel;
    logic [23:0]           word_in;
    logic                  unused_bits;

    // Only the low 24 bits carry colour; the rest of the word is don't-care.
    assign word_in     = bus.wb_received_word[23:0];
    assign unused_bits = ^bus.wb_received_word[DATA_WIDTH-1:24];

    // A word only counts when we actually asked for it.
    assign arrival    = bus.wb_recieved_new_word && outstanding_reg;
    assign bit_end    = (bit_cnt_reg == BIT_LAST);
    assign pixel_end  = bit_end && (bit_idx_reg == 5'd0);
    assign last_pixel = ((pixels_sent_reg + 16'd1) == NUM_LEDS_W);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_next       = state_reg;
        buf_id_next      = buf_id_reg;
        shift_next       = shift_reg;
        hold_next        = hold_reg;
        hold_valid_next  = hold_valid_reg;
        outstanding_next = outstanding_reg;
        bit_idx_next     = bit_idx_reg;
        bit_cnt_next     = bit_cnt_reg;
        latch_cnt_next   = latch_cnt_reg;
        words_req_next   = words_req_reg;
        pixels_sent_next = pixels_sent_reg;
        underrun_next    = underrun_reg;
        req_first_next   = 1'b0;
        req_next_next    = 1'b0;
        frame_done_next  = 1'b0;

        if (arrival) begin
            outstanding_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (bus.frame_start) begin
                    buf_id_next      = bus.frame_buf_id;
                    words_req_next   = 16'd1;
                    pixels_sent_next = 16'd0;
                    bit_cnt_next     = 16'd0;
                    bit_idx_next     = 5'd23;
                    latch_cnt_next   = 32'd0;
                    hold_valid_next  = 1'b0;
                    underrun_next    = 1'b0;
                    outstanding_next = 1'b1;
                    req_first_next   = 1'b1;
                    state_next       = FETCH;
                end
            end

            FETCH, STALL: begin
                if (arrival) begin
                    shift_next   = word_in;
                    bit_idx_next = 5'd23;
                    bit_cnt_next = 16'd0;
                    state_next   = SHIFT;
                end
            end

            SHIFT: begin
                if (!bit_end) begin
                    bit_cnt_next = bit_cnt_reg + 16'd1;
                end else begin
                    bit_cnt_next = 16'd0;
                    if (bit_idx_reg != 5'd0) begin
                        bit_idx_next = bit_idx_reg - 5'd1;
                        shift_next   = {shift_reg[22:0], 1'b0};
                    end else begin
                        pixels_sent_next = pixels_sent_reg + 16'd1;
                        bit_idx_next     = 5'd23;
                        if (last_pixel) begin
                            latch_cnt_next = 32'd0;
                            state_next     = LATCH;
                        end else if (hold_valid_reg) begin
                            shift_next      = hold_reg;
                            hold_valid_next = 1'b0;
                        end else if (arrival) begin
                            // Word lands exactly on the pixel boundary with the
                            // hold empty: feed it straight in rather than parking
                            // it in hold and stalling with nothing left to wake us.
                            shift_next = word_in;
                        end else begin
                            underrun_next = 1'b1;
                            state_next    = STALL;
                        end
                    end
                end
                // Any other arrival refills hold; when a transfer happens in the
                // same cycle the shifter already took the old hold content above.
                if (arrival && !(pixel_end && !last_pixel && !hold_valid_reg)) begin
                    hold_next       = word_in;
                    hold_valid_next = 1'b1;
                end
            end

            LATCH: begin
                if (latch_cnt_reg == LATCH_LAST) begin
                    frame_done_next = 1'b1;
                    state_next      = IDLE;
                end else begin
                    latch_cnt_next = latch_cnt_reg + 32'd1;
                end
            end

            default: state_next = IDLE;
        endcase

        // Prefetch the next word whenever the hold slot is free and nothing is in flight.
        if (((state_reg == SHIFT) || (state_reg == STALL)) && !outstanding_reg &&
            !hold_valid_reg && (words_req_reg < NUM_LEDS_W)) begin
            req_next_next    = 1'b1;
            outstanding_next = 1'b1;
            words_req_next   = words_req_reg + 16'd1;
        end

        led_next  = (state_next == SHIFT) &&
                    (bit_cnt_next < (shift_next[23] ? T1H_W : T0H_W));
        busy_next = (state_next != IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_id_reg      <= '0;
            shift_reg       <= '0;
            hold_reg        <= '0;
            hold_valid_reg  <= 1'b0;
            outstanding_reg <= 1'b0;
            bit_idx_reg     <= 5'd0;
            bit_cnt_reg     <= 16'd0;
            latch_cnt_reg   <= 32'd0;
            words_req_reg   <= 16'd0;
            pixels_sent_reg <= 16'd0;
            req_first_reg   <= 1'b0;
            req_next_reg    <= 1'b0;
            led_reg         <= 1'b0;
            busy_reg        <= 1'b0;
            frame_done_reg  <= 1'b0;
            underrun_reg    <= 1'b0;
        end else begin
            buf_id_reg      <= buf_id_next;
            shift_reg       <= shift_next;
            hold_reg        <= hold_next;
            hold_valid_reg  <= hold_valid_next;
            outstanding_reg <= outstanding_next;
            bit_idx_reg     <= bit_idx_next;
            bit_cnt_reg     <= bit_cnt_next;
            latch_cnt_reg   <= latch_cnt_next;
            words_req_reg   <= words_req_next;
            pixels_sent_reg <= pixels_sent_next;
            req_first_reg   <= req_first_next;
            req_next_reg    <= req_next_next;
            led_reg         <= led_next;
            busy_reg        <= busy_next;
            frame_done_reg  <= frame_done_next;
            underrun_reg    <= underrun_next;
        end
    end

    assign bus.buf_id                = buf_id_reg;
    assign bus.wb_request_first_word = req_first_reg;
    assign bus.wb_request_next_word  = req_next_reg;
    assign bus.led_dout              = led_reg;
    assign bus.busy                  = busy_reg;
    assign bus.frame_done            = frame_done_reg;
    assign bus.underrun              = underrun_reg;
endmodule

// File: tb/tb_led_pixel_shifter.sv
// Directed bench for led_pixel_shifter with a 3-pixel frame, 8-cycle bits
// (0 = 2 high, 1 = 5 high) and a 20-cycle latch.
module tb_led_pixel_shifter;
    localparam int PIXEL_CYCLES = 24 * 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    led_pixel_shifter_if #(.DATA_WIDTH(32)) bus ();

    led_pixel_shifter #(
        .DATA_WIDTH  (32),
        .NUM_LEDS    (3),
        .BIT_CYCLES  (8),
        .T0H         (2),
        .T1H         (5),
        .LATCH_CYCLES(20)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   n_first = 0;
    int   n_next  = 0;
    int   n_done  = 0;
    int   done_idx = -1;
    logic led_q [$];

    // Per-cycle record of the LED line and pulse counts, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.wb_request_first_word === 1'b1) n_first <= n_first + 1;
        if (bus.wb_request_next_word === 1'b1)  n_next  <= n_next + 1;
        if (bus.frame_done === 1'b1) begin
            n_done   <= n_done + 1;
            done_idx <= led_q.size();
        end
        led_q.push_back(bus.led_dout);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (bus.wb_request_first_word || bus.wb_request_next_word) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check({tag, "_req"}, 32'(seen), 32'd1);
    endtask

    task automatic deliver(input logic [31:0] word, input int delay);
        steps(delay);
        bus.wb_received_word     = word;
        bus.wb_recieved_new_word = 1'b1;
        step();
        bus.wb_recieved_new_word = 1'b0;
        bus.wb_received_word     = '0;
    endtask

    task automatic serve(input string tag, input logic [31:0] word, input int delay, input int limit);
        wait_req(tag, limit);
        deliver(word, delay);
    endtask

    task automatic start_frame(input logic [31:0] id);
        bus.frame_buf_id = id;
        bus.frame_start  = 1'b1;
        step();
        bus.frame_start  = 1'b0;
        bus.frame_buf_id = '0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int base = n_done;
        for (int i = 0; i < limit && n_done == base; i++) step();
        steps(5);
        check({tag, "_done_pulses"}, 32'(n_done - base), 32'd1);
    endtask

    function automatic int first_one(input int from);
        for (int i = from; i < led_q.size(); i++)
            if (led_q[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int ones(input int from, input int to);
        int n = 0;
        for (int i = from; i < to; i++)
            if (i >= 0 && i < led_q.size() && led_q[i] === 1'b1) n++;
        return n;
    endfunction

    // Number of 8-cycle bit windows starting at 'start' whose shape differs from px.
    function automatic int bad_windows(input int start, input logic [23:0] px);
        int bad = 0;
        for (int b = 0; b < 24; b++) begin
            int hi;
            bit wrong;
            hi    = px[23 - b] ? 5 : 2;
            wrong = 1'b0;
            for (int c = 0; c < 8; c++) begin
                int idx;
                idx = start + b * 8 + c;
                if (idx < 0 || idx >= led_q.size()) wrong = 1'b1;
                else if (led_q[idx] !== ((c < hi) ? 1'b1 : 1'b0)) wrong = 1'b1;
            end
            if (wrong) bad++;
        end
        return bad;
    endfunction

    initial begin
        int base, s, s2, nf, nn;

        bus.frame_start          = 1'b0;
        bus.frame_buf_id         = '0;
        bus.wb_recieved_new_word = 1'b0;
        bus.wb_received_word     = '0;

        // Reset values
        reset = 1'b0;
        steps(3);
        check("rst_led", bus.led_dout, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_buf_id", bus.buf_id, 0);
        check("rst_req_first", bus.wb_request_first_word, 0);
        check("rst_req_next", bus.wb_request_next_word, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_underrun", bus.underrun, 0);
        reset = 1'b1;
        steps(2);

        // Frame 1: prompt fetch stage, contiguous pixels
        base = led_q.size(); nf = n_first; nn = n_next;
        start_frame(32'd7);
        check("f1_buf_id", bus.buf_id, 7);
        check("f1_req_first", bus.wb_request_first_word, 1);
        check("f1_busy", bus.busy, 1);
        serve("f1_w0", 32'h0080_0001, 2, 20);
        check("f1_led_rise", bus.led_dout, 1);
        serve("f1_w1", 32'hFF00_FF00, 2, 20);
        serve("f1_w2", 32'h1234_5678, 2, 300);
        wait_done("f1", 1000);
        s = first_one(base);
        check("f1_bit23_high", 32'(ones(s, s + 8)), 5);
        check("f1_bit22_high", 32'(ones(s + 8, s + 16)), 2);
        check("f1_bit0_high", 32'(ones(s + 184, s + 192)), 5);
        check("f1_pixel_bits", 32'(bad_windows(s, 24'h800001) +
                                   bad_windows(s + PIXEL_CYCLES, 24'h00FF00) +
                                   bad_windows(s + 2 * PIXEL_CYCLES, 24'h345678)), 0);
        check("f1_latch_low", 32'(ones(s + 576, s + 596)), 0);
        check("f1_done_at", 32'(done_idx - s), 596);
        check("f1_underrun", bus.underrun, 0);
        check("f1_first_reqs", 32'(n_first - nf), 1);
        check("f1_next_reqs", 32'(n_next - nn), 2);
        check("f1_busy_end", bus.busy, 0);

        // Frame 2: second word 300 cycles late -> stall and underrun
        base = led_q.size(); nf = n_first; nn = n_next;
        start_frame(32'd3);
        serve("f2_w0", 32'h00F0_F0F0, 2, 20);
        wait_req("f2_w1", 20);
        steps(250);
        check("f2_stall_led", bus.led_dout, 0);
        check("f2_stall_underrun", bus.underrun, 1);
        check("f2_stall_busy", bus.busy, 1);
        deliver(32'h000F_0F0F, 50);
        serve("f2_w2", 32'hAB55_5555, 2, 300);
        wait_done("f2", 1000);
        s  = first_one(base);
        s2 = first_one(s + PIXEL_CYCLES);
        check("f2_px0_bits", 32'(bad_windows(s, 24'hF0F0F0)), 0);
        check("f2_resume_at", 32'(s2 - s), 302);
        check("f2_px12_bits", 32'(bad_windows(s2, 24'h0F0F0F) +
                                  bad_windows(s2 + PIXEL_CYCLES, 24'h555555)), 0);
        check("f2_done_at", 32'(done_idx - s2), 404);
        check("f2_underrun_sticky", bus.underrun, 1);
        check("f2_next_reqs", 32'(n_next - nn), 2);

        // Frame 3: unsolicited word in IDLE, frame_start while shifting
        nf = n_first; nn = n_next;
        deliver(32'h00FF_FFFF, 0);
        steps(3);
        check("f3_stray_busy", bus.busy, 0);
        check("f3_stray_led", bus.led_dout, 0);
        check("f3_stray_reqs", 32'((n_first - nf) + (n_next - nn)), 0);
        base = led_q.size();
        start_frame(32'd5);
        check("f3_underrun_cleared", bus.underrun, 0);
        serve("f3_w0", 32'h00C3_C3C3, 2, 20);
        serve("f3_w1", 32'h003C_3C3C, 2, 20);
        steps(10);
        start_frame(32'd9);
        steps(2);
        check("f3_buf_id_kept", bus.buf_id, 5);
        check("f3_no_extra_first", 32'(n_first - nf), 1);
        serve("f3_w2", 32'h0099_9999, 2, 300);
        wait_done("f3", 1000);
        s = first_one(base);
        check("f3_pixel_bits", 32'(bad_windows(s, 24'hC3C3C3) +
                                   bad_windows(s + PIXEL_CYCLES, 24'h3C3C3C) +
                                   bad_windows(s + 2 * PIXEL_CYCLES, 24'h999999)), 0);
        check("f3_done_at", 32'(done_idx - s), 596);
        check("f3_next_reqs", 32'(n_next - nn), 2);

        // Frame 4: reset while pixel 2 is high on the line
        nf = n_first; nn = n_next;
        start_frame(32'd6);
        serve("f4_w0", 32'h0012_3456, 2, 20);
        serve("f4_w1", 32'h00FF_FFFF, 2, 20);
        wait_req("f4_w2", 300);
        steps(2);
        check("f4_led_before_reset", bus.led_dout, 1);
        reset = 1'b0;
        step();
        check("f4_rst_led", bus.led_dout, 0);
        check("f4_rst_busy", bus.busy, 0);
        check("f4_rst_buf_id", bus.buf_id, 0);
        check("f4_rst_reqs", 32'({bus.wb_request_first_word, bus.wb_request_next_word}), 0);
        check("f4_rst_flags", 32'({bus.frame_done, bus.underrun}), 0);
        reset = 1'b1;
        step();
        deliver(32'h00AA_AAAA, 0);
        steps(5);
        check("f4_late_word_busy", bus.busy, 0);
        check("f4_late_word_led", bus.led_dout, 0);
        check("f4_total_next_reqs", 32'(n_next - nn), 2);

        // Frame 5: clean frame after the aborted one
        base = led_q.size(); nf = n_first; nn = n_next;
        start_frame(32'd11);
        serve("f5_w0", 32'h00A1_B2C3, 2, 20);
        serve("f5_w1", 32'h00FF_FFFF, 2, 20);
        serve("f5_w2", 32'h0000_0000, 2, 300);
        wait_done("f5", 1000);
        s = first_one(base);
        check("f5_pixel_bits", 32'(bad_windows(s, 24'hA1B2C3) +
                                   bad_windows(s + PIXEL_CYCLES, 24'hFFFFFF) +
                                   bad_windows(s + 2 * PIXEL_CYCLES, 24'h000000)), 0);
        check("f5_done_at", 32'(done_idx - s), 596);
        check("f5_buf_id", bus.buf_id, 11);
        check("f5_underrun", bus.underrun, 0);
        check("f5_reqs", 32'((n_first - nf) + (n_next - nn)), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
